gray_conv_arbiter: RTL and testbench
====================================

// Module: gray_conv_arbiter
// PURPOSE
//  Shares one serial Gray-to-binary conversion engine among N_REQ requesters.
//  A round-robin arbiter grants one request and captures that requester's Gray word.
//  The engine converts it MSB-first, one bit per clock (b[i] = b[i+1] ^ g[i]).
//  It then presents the binary result and requester ID on a valid/ready output.
//  Sits between encoder/pointer sources and downstream binary consumers.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2)
//  WIDTH  4  Gray/binary word width in bits (>=2)
//  ID_W   localparam = $clog2(N_REQ), width of b_id
// PORTS
//  clk      in   1            rising-edge clock
//  rst_n    in   1            synchronous active-low reset
//  req      in   N_REQ        per-requester request level
//  g_in     in   N_REQ*WIDTH  Gray words; requester k uses g_in[k*WIDTH +: WIDTH]
//  ack      out  N_REQ        one-cycle registered capture pulse, at most one bit set
//  b_out    out  WIDTH        converted binary result
//  b_id     out  ID_W         index of the requester that owns b_out
//  b_valid  out  1            b_out/b_id valid
//  b_ready  in   1            downstream accepts the result when high with b_valid
// BEHAVIOUR
//  Reset (rst_n low at a clk edge):
//   state=IDLE; ack=0; b_out=0; b_id=0; b_valid=0; rr_ptr=0; bit counter=0.
//   A reset in any state aborts the conversion in progress. No ack or b_valid is
//   issued for an aborted word.
//  FSM states: IDLE -> CONV -> DONE -> IDLE.
//  IDLE:
//   - If no req bit is set, stay in IDLE.
//   - Otherwise grant k = first set req bit at or after rr_ptr, searching upward
//     with wrap-around.
//   - At that edge: latch g_in slice k; b_id<=k; ack[k]<=1 for exactly one cycle;
//     rr_ptr<=(k+1) mod N_REQ; state->CONV.
//  CONV:
//   - Edge 1: b_out[WIDTH-1] <= g[WIDTH-1].
//   - Edge j (j = 2..WIDTH): b_out[WIDTH-j] <= b_out[WIDTH-j+1] ^ g[WIDTH-j].
//   - At edge WIDTH: b_valid<=1, state->DONE.
//  DONE:
//   - Hold b_out, b_id and b_valid stable while b_ready is low; no new grant.
//   - On an edge with b_valid & b_ready: b_valid<=0, state->IDLE.
//   - b_out and b_id keep their last values after the handshake.
//  Latency: b_valid rises WIDTH+1 edges after the req is sampled in IDLE. The
//   earliest next grant is 1 edge after the handshake edge.
//   Minimum period per word = WIDTH+2 cycles.
//  Requester rules:
//   - Sampling happens only in IDLE.
//   - Hold req and g_in stable until ack is seen.
//   - Drop req in the cycle after ack unless another word is pending.
//   - A req still high when the FSM next reaches IDLE counts as a new request.
//  Simultaneous requests: resolved by rr_ptr only. Non-requesting indices are
//   skipped. No requester waits more than N_REQ-1 grants.
//  Changes on g_in after capture do not affect the word being converted.
//  b_ready high while b_valid is low has no effect.
// TESTING
//  1 Reset, req=0001, g0=1011 -> ack=0001 for 1 cycle; b_valid after 5 edges;
//    b_out=1101, b_id=0.
//  2 Single requester: g=0000 -> 0000; g=1000 -> 1111; g=0001 -> 0001; g=1111 -> 1010.
//    Check all with b_ready tied high.
//  3 After reset, req=1111 held continuously -> grant order 0,1,2,3,0.
//    ack pulses are spaced WIDTH+2 cycles apart.
//  4 b_ready low 5 cycles in DONE -> b_valid, b_out, b_id stable; ack stays 0.
//    Raise b_ready -> 1 handshake, next grant 1 edge later.
//  5 Assert rst_n=0 at edge 2 of CONV -> all outputs 0 next edge; no b_valid.
//    After release, req still high -> fresh grant from rr_ptr=0.
//  6 WIDTH=8, N_REQ=3, g=8'b1100_0011 -> b_out=8'b1000_0010 after 9 edges.
//    rr wrap 2 -> 0 works.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared serial Gray-to-binary engine.
// The granted word is converted MSB-first, one bit per clock, then offered on valid/ready.
module gray_conv_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] g_in,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       b_out,
  output logic [ID_W-1:0]        b_id,
  output logic                   b_valid,
  input  logic                   b_ready
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   g_q, g_d;
  logic [WIDTH-1:0]   b_out_q, b_out_d;
  logic [ID_W-1:0]    b_id_q, b_id_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               found_hi, found_lo;
  logic [ID_W-1:0]    hi_idx, lo_idx, grant_c;
  logic [WIDTH-1:0]   g_sel_c;
  logic [CNT_W-1:0]   bit_c, bit_up_c;

  // Round-robin pick: lowest request at/above rr_q, else lowest request overall (wrap).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    g_sel_c  = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (req[k] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = ID_W'(k);
      end
      if (req[k] && !found_hi && (ID_W'(k) >= rr_q)) begin
        found_hi = 1'b1;
        hi_idx   = ID_W'(k);
      end
    end
    grant_c = found_hi ? hi_idx : lo_idx;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (ID_W'(k) == grant_c) g_sel_c = g_in[k*WIDTH +: WIDTH];
    end
  end

  // Bit being produced this cycle and its already-converted upper neighbour.
  assign bit_c    = CNT_W'(WIDTH - 1) - cnt_q;
  assign bit_up_c = bit_c + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    b_out_d = b_out_q;
    b_id_d  = b_id_q;
    ack_d   = '0;
    valid_d = valid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          g_d            = g_sel_c;
          b_id_d         = grant_c;
          ack_d[grant_c] = 1'b1;
          rr_d           = (grant_c == ID_W'(N_REQ - 1)) ? '0 : grant_c + ID_W'(1);
          cnt_d          = '0;
          state_d        = CONV;
        end
      end
      CONV: begin
        if (cnt_q == '0) b_out_d[WIDTH-1] = g_q[WIDTH-1];
        else             b_out_d[bit_c]   = b_out_q[bit_up_c] ^ g_q[bit_c];
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (b_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      b_out_q <= '0;
      b_id_q  <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      b_out_q <= b_out_d;
      b_id_q  <= b_id_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack     = ack_q;
  assign b_out   = b_out_q;
  assign b_id    = b_id_q;
  assign b_valid = valid_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: a 4x4 instance with a result scoreboard and a 3x8 instance
// for the wide-word and 3-way wrap cases.
module tb_gray_conv_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_a;
  logic [15:0] g_a;
  logic [3:0]  ack_a;
  logic [3:0]  b_out_a;
  logic [1:0]  b_id_a;
  logic        b_valid_a;
  logic        b_ready_a;
  logic [2:0]  req_b;
  logic [23:0] g_b;
  logic [2:0]  ack_b;
  logic [7:0]  b_out_b;
  logic [1:0]  b_id_b;
  logic        b_valid_b;
  logic        b_ready_b;

  typedef struct {
    int         id;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   rr_m;

  gray_conv_arbiter #(.N_REQ(4), .WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .g_in(g_a), .ack(ack_a),
    .b_out(b_out_a), .b_id(b_id_a), .b_valid(b_valid_a), .b_ready(b_ready_a)
  );

  gray_conv_arbiter #(.N_REQ(3), .WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .g_in(g_b), .ack(ack_b),
    .b_out(b_out_b), .b_id(b_id_b), .b_valid(b_valid_b), .b_ready(b_ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Binary value is the XOR of all right-shifts of the Gray word.
  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int rr);
    for (int off = 0; off < 4; off++) begin
      if (r[(rr + off) % 4]) return (rr + off) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Predict the grant for the current request vector and queue its result.
  task automatic push_a(output int id);
    exp_t e;
    id   = rr_pick(req_a, rr_m);
    rr_m = (id + 1) % 4;
    e.id = id;
    e.b  = gray2bin({4'b0, g_a[id*4 +: 4]});
    exp_q.push_back(e);
  endtask

  task automatic wait_ack_a(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (ack_a == 4'b0 && cyc < 30);
    if (ack_a == 4'b0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid_a();
    int i;
    i = 0;
    while (b_valid_a !== 1'b1 && i < 30) begin
      step();
      i++;
    end
    if (b_valid_a !== 1'b1) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    rr_m  = 0;
  endtask

  // Scoreboard: every accepted result on dut_a must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && b_valid_a === 1'b1 && b_ready_a === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_b_out", 32'(b_out_a), 32'(e.b));
        check("sb_b_id", 32'(b_id_a), 32'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    int cyc;
    int ids[5];
    logic [3:0] t2_g[4];
    logic [3:0] t2_b[4];
    n_checks = 0;
    n_fail   = 0;
    rr_m     = 0;
    req_a = '0; g_a = '0; b_ready_a = 1'b1;
    req_b = '0; g_b = '0; b_ready_b = 1'b1;
    rst_n = 1'b0;

    // Reset values and the basic single-word transaction
    do_reset();
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_valid", 32'(b_valid_a), 32'd0);
    check("rst_b_out", 32'(b_out_a), 32'd0);
    check("rst_b_id", 32'(b_id_a), 32'd0);
    check("rst_valid_b", 32'(b_valid_b), 32'd0);
    g_a[3:0] = 4'b1011;
    req_a    = 4'b0001;
    push_a(id);
    step();
    check("t1_ack", 32'(ack_a), 32'b0001);
    req_a = '0;
    step();
    check("t1_ack_pulse", 32'(ack_a), 32'd0);
    repeat (2) step();
    check("t1_not_early", 32'(b_valid_a), 32'd0);
    step();
    check("t1_valid", 32'(b_valid_a), 32'd1);
    check("t1_b_out", 32'(b_out_a), 32'b1101);
    check("t1_b_id", 32'(b_id_a), 32'd0);
    step();
    check("t1_hs", 32'(b_valid_a), 32'd0);

    // Single requester, several Gray patterns
    t2_g = '{4'b0000, 4'b1000, 4'b0001, 4'b1111};
    t2_b = '{4'b0000, 4'b1111, 4'b0001, 4'b1010};
    for (int n = 0; n < 4; n++) begin
      g_a[3:0] = t2_g[n];
      req_a    = 4'b0001;
      push_a(id);
      wait_ack_a(cyc);
      check("t2_ack", 32'(ack_a), 32'b0001);
      req_a = '0;
      wait_valid_a();
      check("t2_b_out", 32'(b_out_a), 32'(t2_b[n]));
      step();
    end

    // All four requesting: round-robin order and minimum spacing
    do_reset();
    g_a   = {4'b0011, 4'b1110, 4'b0110, 4'b1011};
    req_a = 4'b1111;
    for (int n = 0; n < 5; n++) push_a(ids[n]);
    for (int n = 0; n < 5; n++) begin
      wait_ack_a(cyc);
      check("t3_ack", 32'(ack_a), 32'(4'b0001 << ids[n]));
      if (n > 0) check("t3_gap", 32'(cyc), 32'd6);
    end
    req_a = '0;
    wait_valid_a();
    step();

    // Backpressure in DONE with another requester waiting
    b_ready_a = 1'b0;
    req_a     = 4'b0100;
    push_a(id);
    wait_ack_a(cyc);
    check("t4_ack", 32'(ack_a), 32'b0100);
    req_a = 4'b0010;
    wait_valid_a();
    for (int n = 0; n < 5; n++) begin
      step();
      check("t4_hold_valid", 32'(b_valid_a), 32'd1);
      check("t4_hold_b_out", 32'(b_out_a), 32'b1011);
      check("t4_hold_b_id", 32'(b_id_a), 32'd2);
      check("t4_no_ack", 32'(ack_a), 32'd0);
    end
    push_a(id);
    b_ready_a = 1'b1;
    step();
    check("t4_hs", 32'(b_valid_a), 32'd0);
    step();
    check("t4_next_ack", 32'(ack_a), 32'b0010);
    req_a = '0;
    wait_valid_a();
    step();

    // Reset during conversion aborts the word; rr pointer restarts at 0
    req_a = 4'b0011;
    wait_ack_a(cyc);
    check("t5_ack_abort", 32'(ack_a), 32'b0001);
    step();
    rst_n = 1'b0;
    step();
    check("t5_rst_ack", 32'(ack_a), 32'd0);
    check("t5_rst_valid", 32'(b_valid_a), 32'd0);
    check("t5_rst_b_out", 32'(b_out_a), 32'd0);
    check("t5_rst_b_id", 32'(b_id_a), 32'd0);
    rst_n = 1'b1;
    rr_m  = 0;
    push_a(id);
    step();
    check("t5_fresh_ack", 32'(ack_a), 32'b0001);
    req_a = 4'b0010;
    push_a(id);
    wait_valid_a();
    step();
    wait_ack_a(cyc);
    check("t5_ack1", 32'(ack_a), 32'b0010);
    req_a = '0;
    wait_valid_a();
    step();

    // Wide word on the 3-requester instance and rr wrap 2 -> 0
    do_reset();
    g_b[16 +: 8] = 8'b1100_0011;
    g_b[7:0]     = 8'h5A;
    req_b        = 3'b100;
    step();
    check("t6_ack2", 32'(ack_b), 32'b100);
    req_b = 3'b001;
    repeat (7) step();
    check("t6_not_early", 32'(b_valid_b), 32'd0);
    step();
    check("t6_valid", 32'(b_valid_b), 32'd1);
    check("t6_b_out", 32'(b_out_b), 32'b1000_0010);
    check("t6_b_out_model", 32'(b_out_b), 32'(gray2bin(8'b1100_0011)));
    check("t6_b_id", 32'(b_id_b), 32'd2);
    step();
    check("t6_hs", 32'(b_valid_b), 32'd0);
    step();
    check("t6_wrap_ack", 32'(ack_b), 32'b001);
    req_b = '0;
    repeat (8) step();
    check("t6_valid0", 32'(b_valid_b), 32'd1);
    check("t6_b_out0", 32'(b_out_b), 32'(gray2bin(8'h5A)));
    check("t6_b_id0", 32'(b_id_b), 32'd0);
    step();

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
